// File: rtl/fxp_pkg.sv
// Shared definitions for the signed fixed-point datapath blocks.
// Holds the divider FSM states, the default Q7.8 format and the helpers
// for saturation limits, absolute value and negation.
package fxp_pkg;

    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } fxp_state_e;

    // Largest positive value of a width-bit two's complement number.
    function automatic logic [31:0] fxp_max(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Bit pattern of the most negative value; also the magnitude of that value.
    function automatic logic [31:0] fxp_min(input int width);
        return 32'd1 << (width - 1);
    endfunction

    // Magnitude of a sign-extended value; the most negative input maps to its
    // positive magnitude, which still fits in the unsigned result.
    function automatic logic [31:0] fxp_abs(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

    // Two's complement negation.
    function automatic logic [31:0] fxp_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/fxp_sat_round.sv
// Combinational sign/magnitude to saturated two's complement converter.
// Optional macro FXP_DIV_ROUND_EN: round half away from zero using the
// divider remainder before the saturation check; otherwise truncate.
module fxp_sat_round
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int MAG_W = FXP_WIDTH + FXP_FRAC
) (
    input  logic             sign_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic             overflow_o
);

    localparam logic [MAG_W:0] LIMIT_POS = (MAG_W + 1)'(fxp_max(WIDTH));
    localparam logic [MAG_W:0] LIMIT_NEG = (MAG_W + 1)'(fxp_min(WIDTH));

    logic [MAG_W:0] magRound;

`ifdef FXP_DIV_ROUND_EN
    logic roundUp;

    // Round up when the leftover remainder is at least half the divisor.
    always_comb begin
        roundUp  = ({rem_i, 1'b0} >= {2'b00, divisor_i});
        magRound = {1'b0, mag_i} + (MAG_W + 1)'(roundUp);
    end
`else
    logic unusedRound;

    assign unusedRound = ^{rem_i, divisor_i};

    // Truncation toward zero: the magnitude passes straight through.
    always_comb begin
        magRound = {1'b0, mag_i};
    end
`endif

    // Clamp to the representable range for the result sign, then apply the sign.
    always_comb begin
        quot_o     = '0;
        overflow_o = 1'b0;
        if (sign_i) begin
            if (magRound > LIMIT_NEG) begin
                quot_o     = WIDTH'(fxp_min(WIDTH));
                overflow_o = 1'b1;
            end else begin
                quot_o = WIDTH'(fxp_neg(32'(magRound)));
            end
        end else begin
            if (magRound > LIMIT_POS) begin
                quot_o     = WIDTH'(fxp_max(WIDTH));
                overflow_o = 1'b1;
            end else begin
                quot_o = WIDTH'(magRound);
            end
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider, restoring shift-subtract, one
// quotient bit per cycle, valid/ready on both sides, saturating result.
// Optional macro FXP_DIV_ROUND_EN (inside fxp_sat_round) selects rounding.
module fxp_div_seq
    import fxp_pkg::*;
#(
    parameter int WIDTH     = FXP_WIDTH,
    parameter int FRAC_BITS = FXP_FRAC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] quot,
    output logic                    overflow,
    output logic                    div_by_zero
);

    localparam int N  = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N);

    fxp_state_e       state_q, state_d;
    logic [N-1:0]     div_q, div_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             zeroDiv_q, zeroDiv_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   remShift;
    logic             remGeq;
    logic [WIDTH-1:0] satQuot;
    logic             satOvf;

    fxp_sat_round #(
        .WIDTH (WIDTH),
        .MAG_W (N)
    ) u_sat_round (
        .sign_i     (sign_q),
        .mag_i      (div_q),
        .rem_i      (rem_q),
        .divisor_i  (divisor_q),
        .quot_o     (satQuot),
        .overflow_o (satOvf)
    );

    // Operand magnitudes and the trial subtraction for the current iteration.
    always_comb begin
        absA     = WIDTH'(fxp_abs(32'($signed(a))));
        absB     = WIDTH'(fxp_abs(32'($signed(b))));
        remShift = {rem_q[WIDTH-1:0], div_q[N-1]};
        remGeq   = (remShift >= {1'b0, divisor_q});
    end

    // Next-state logic: accept operands, iterate, saturate, then hold the result.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        zeroDiv_d = zeroDiv_q;
        quot_d    = quot_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d     = {absA, {FRAC_BITS{1'b0}}};
                    rem_d     = '0;
                    divisor_d = absB;
                    cnt_d     = '0;
                    sign_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    zeroDiv_d = (b == '0);
                    state_d   = (b == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = remGeq ? (remShift - {1'b0, divisor_q}) : remShift;
                div_d = {div_q[N-2:0], remGeq};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zeroDiv_q) begin
                    quot_d = sign_q ? WIDTH'(fxp_min(WIDTH)) : WIDTH'(fxp_max(WIDTH));
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = satQuot;
                    ovf_d  = satOvf;
                end
                dbz_d   = zeroDiv_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            zeroDiv_q <= 1'b0;
            quot_q    <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            zeroDiv_q <= zeroDiv_d;
            quot_q    <= quot_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quot        = quot_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed testbench for fxp_div_seq in the default Q7.8 format.
// Expected values are hand-computed; FXP_DIV_ROUND_EN selects rounded results.
module tb_fxp_div_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic        overflow;
    logic        div_by_zero;

    int errors;
    int checks;

    fxp_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One full transaction: handshake in, wait for the result, check, optionally stall, drain.
    task automatic applyStimulus(input string tag, input logic [15:0] aIn, input logic [15:0] bIn,
                                 input logic [15:0] expQuot, input logic expOvf, input logic expDbz,
                                 input int expLat, input int holdCycles);
        int cycles;
        @(negedge clk);
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a        = aIn;
        b        = bIn;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cycles   = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, ".quot"}, 32'(quot), 32'(expQuot));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
        checkOutput({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(expDbz));
        checkOutput({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
        if (holdCycles > 0) begin
            repeat (holdCycles) begin
                @(posedge clk);
                @(negedge clk);
            end
            checkOutput({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".hold_quot"}, 32'(quot), 32'(expQuot));
            checkOutput({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ".drained_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".drained_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [15:0] expThird;
    logic [15:0] expNegThird;

    // Main directed sequence.
    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef FXP_DIV_ROUND_EN
        expThird    = 16'h00AB;
        expNegThird = 16'hFF55;
`else
        expThird    = 16'h00AA;
        expNegThird = 16'hFF56;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.quot", 32'(quot), 32'd0);
        checkOutput("reset.overflow", 32'(overflow), 32'd0);
        checkOutput("reset.div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        applyStimulus("pos_10_div_4",    16'h0A00, 16'h0400, 16'h0280, 1'b0, 1'b0, 25, 10);
        applyStimulus("neg_7p5_div_2p5", 16'hF880, 16'h0280, 16'hFD00, 1'b0, 1'b0, 25, 0);
        applyStimulus("sat_pos",         16'h6400, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 25, 0);
        applyStimulus("sat_neg",         16'h9C00, 16'h0080, 16'h8000, 1'b1, 1'b0, 25, 0);
        applyStimulus("dbz_pos",         16'h0500, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1, 0);
        applyStimulus("dbz_neg",         16'hFB00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1, 0);
        applyStimulus("two_thirds",      16'h0200, 16'h0300, expThird, 1'b0, 1'b0, 25, 0);
        applyStimulus("neg_two_thirds",  16'hFE00, 16'h0300, expNegThird, 1'b0, 1'b0, 25, 0);
        applyStimulus("min_div_one",     16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25, 0);
        applyStimulus("min_div_negone",  16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25, 0);

        // Abort a division mid-CALC with reset.
        @(negedge clk);
        a        = 16'h0A00;
        b        = 16'h0400;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("abort.busy_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort.busy_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort.quot", 32'(quot), 32'd0);
        checkOutput("abort.overflow", 32'(overflow), 32'd0);

        applyStimulus("zero_div_neg",    16'h0000, 16'hFD00, 16'h0000, 1'b0, 1'b0, 25, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
